sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter SRAM_AW, default 19: external SRAM address width.
REQ-002 Parameter SRAM_DW, default 8: external SRAM data width.
REQ-003 Parameter BUS_DW, default 32: host data width; must be an integer multiple of SRAM_DW. LANES = BUS_DW/SRAM_DW, LB = log2(LANES).
REQ-004 Parameter WAIT_CYCLES, default 2 (minimum 1): SRAM strobe-low cycles per lane. Lane period L = WAIT_CYCLES+1.
REQ-005 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port req, input, 1: host request; held high until ack is seen.
REQ-008 Port wren, input, 1: 1 = write, 0 = read.
REQ-009 Port addr, input, SRAM_AW-LB: host word address.
REQ-010 Port be, input, LANES: write byte-lane enables; ignored for reads.
REQ-011 Port wrdata, input, BUS_DW: write data; lane i = wrdata[i*SRAM_DW +: SRAM_DW].
REQ-012 Port ack, output, 1: one-cycle completion pulse.
REQ-013 Port rddata, output, BUS_DW: read data; valid with ack, held until the next read completes.
REQ-014 Port sram_a, output, SRAM_AW: SRAM address.
REQ-015 Port sram_dq, inout, SRAM_DW: SRAM data bus.
REQ-016 Ports sram_ce_n, sram_oe_n, sram_we_n, output, 1 each: active-low SRAM strobes, all registered.

Function
REQ-017 State machine: IDLE, LANE, DONE.
REQ-018 In IDLE, a rising edge with req=1 captures wren, addr, be and wrdata, then enters LANE at the first enabled lane; all later input changes are ignored until DONE.
REQ-019 A write with be=0 goes IDLE->DONE directly and issues no SRAM strobes.
REQ-020 Reads access all lanes 0..LANES-1. Writes access only lanes with be[i]=1, in ascending order; disabled lanes take zero cycles.
REQ-021 During a lane: sram_a = {captured addr, i}, sram_ce_n = 0, and the lane lasts exactly L cycles.
REQ-022 Read lane: sram_oe_n = 0 for all L cycles, sram_dq is high-Z, and sram_dq is sampled into rddata lane i at the edge that ends the lane.
REQ-023 Write lane: sram_we_n = 0 for the first WAIT_CYCLES cycles and 1 in the last cycle. sram_dq is driven with lane data for all L cycles, so address and data are held across the WE rising edge. sram_oe_n stays 1.
REQ-024 After the last accessed lane, state goes to DONE: ack = 1 for exactly one cycle and all strobes = 1. DONE goes to IDLE unconditionally.
REQ-025 Read latency from the accepting edge to ack is LANES*L+1 cycles. Write latency is (enabled lanes)*L+1 cycles.
REQ-026 Back-to-back requests: at least one IDLE cycle with sram_ce_n = 1 separates transactions. The host drops req on the edge where it samples ack; req still high in IDLE starts a new transaction.
REQ-027 Outside LANE: sram_ce_n = sram_oe_n = sram_we_n = 1 and sram_dq is high-Z. sram_a holds its last value.
REQ-028 sram_dq is never driven while sram_oe_n = 0. sram_we_n and sram_oe_n are never 0 simultaneously.

Reset
REQ-029 reset_n = 0 immediately forces: state IDLE; ack = 0; rddata = 0; sram_a = 0; sram_ce_n = sram_oe_n = sram_we_n = 1; sram_dq high-Z.
REQ-030 Reset during LANE aborts the transaction with no ack. A partially written word is acceptable. The first edge after release with req=1 starts a fresh transaction.

Verification
REQ-031 Defaults, behavioural 512K x 8 async SRAM model, write addr=0x100, be=4'b1111, wrdata=0xDEADBEEF -> SRAM bytes 0x400..0x403 = EF,BE,AD,DE; ack exactly 13 cycles after the accepting edge.
REQ-032 Read addr=0x100 after REQ-031 -> rddata = 0xDEADBEEF with ack 13 cycles after acceptance; sram_oe_n low 12 cycles; sram_dq never driven.
REQ-033 Write be=4'b0101, wrdata=0x11223344 over 0xDEADBEEF -> bytes = 44,BE,22,DE; ack after 7 cycles.
REQ-034 Write be=4'b0000 -> ack 1 cycle after acceptance; no strobe toggles; memory unchanged.
REQ-035 Assert reset_n = 0 in cycle 5 of a read -> strobes high and dq high-Z in the same cycle; no ack. After release, a new read returns correct data.
REQ-036 Back-to-back write then read with req held continuously -> exactly one IDLE cycle between them with sram_ce_n = 1, and the read returns the just-written data. Repeat with WAIT_CYCLES = 1 and BUS_DW = 16: ack latency 5 cycles for a read.

Source files
------------

// File: rtl/sram_ctrl.sv
// Bridges a wide host bus to a narrow asynchronous SRAM. Each host word is split into
// SRAM-width lanes. Each lane lasts WAIT_CYCLES+1 clocks, and every SRAM strobe comes from a flop.
module sram_ctrl #(
  parameter int SRAM_AW     = 19,
  parameter int SRAM_DW     = 8,
  parameter int BUS_DW      = 32,
  parameter int WAIT_CYCLES = 2,
  localparam int LANES      = BUS_DW / SRAM_DW,
  localparam int LB         = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  wren,
  input  logic [SRAM_AW-LB-1:0] addr,
  input  logic [LANES-1:0]      be,
  input  logic [BUS_DW-1:0]     wrdata,
  output logic                  ack,
  output logic [BUS_DW-1:0]     rddata,
  output logic [SRAM_AW-1:0]    sram_a,
  inout  wire  [SRAM_DW-1:0]    sram_dq,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  localparam int LW  = (LB > 0) ? LB : 1;
  localparam int CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int HAW = SRAM_AW - LB;
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LANE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [LW-1:0]      r_lane;
  logic [CW-1:0]      r_cnt;
  logic               r_wren;
  logic [HAW-1:0]     r_addr;
  logic [LANES-1:0]   r_be;
  logic [BUS_DW-1:0]  r_wrdata;
  logic               r_ack;
  logic [BUS_DW-1:0]  r_rddata;
  logic [SRAM_AW-1:0] r_sram_a;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_dq_oe;
  logic [SRAM_DW-1:0] r_dq_out;

  state_t             w_state_nxt;
  logic [LW-1:0]      w_lane_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_wren_nxt;
  logic [HAW-1:0]     w_addr_nxt;
  logic [LANES-1:0]   w_be_nxt;
  logic [BUS_DW-1:0]  w_wrdata_nxt;
  logic               w_sample;
  logic [LW:0]        w_next;
  logic               w_in_lane;
  logic [SRAM_AW-1:0] w_sram_a_nxt;
  logic [SRAM_DW-1:0] w_dq_nxt;

  // Lowest lane index >= from that is set in mask; MSB flags whether one exists.
  function automatic logic [LW:0] find_lane(input logic [LANES-1:0] mask, input int from);
    logic [LW:0] res;
    res = {(LW+1){1'b0}};
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        res = {1'b1, LW'(i)};
      end
    end
    return res;
  endfunction

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    w_state_nxt  = r_state;
    w_lane_nxt   = r_lane;
    w_cnt_nxt    = r_cnt;
    w_wren_nxt   = r_wren;
    w_addr_nxt   = r_addr;
    w_be_nxt     = r_be;
    w_wrdata_nxt = r_wrdata;
    w_sample     = 1'b0;
    w_next       = {(LW+1){1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_wren_nxt   = wren;
          w_addr_nxt   = addr;
          w_be_nxt     = be;
          w_wrdata_nxt = wrdata;
          w_next       = find_lane(wren ? be : {LANES{1'b1}}, 0);
          if (w_next[LW]) begin
            w_state_nxt = ST_LANE;
            w_lane_nxt  = w_next[LW-1:0];
            w_cnt_nxt   = {CW{1'b0}};
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LANE: begin
        if (r_cnt == LAST_CNT) begin
          w_sample = ~r_wren;
          w_next   = find_lane(r_wren ? r_be : {LANES{1'b1}}, int'(r_lane) + 1);
          if (w_next[LW]) begin
            w_state_nxt = ST_LANE;
            w_lane_nxt  = w_next[LW-1:0];
            w_cnt_nxt   = {CW{1'b0}};
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_in_lane    = (w_state_nxt == ST_LANE);
    w_sram_a_nxt = w_in_lane ? ((SRAM_AW'(w_addr_nxt) << LB) | SRAM_AW'(w_lane_nxt)) : r_sram_a;
    w_dq_nxt     = w_wrdata_nxt[int'(w_lane_nxt)*SRAM_DW +: SRAM_DW];
  end

  // State, captured request and registered SRAM pins; WE rises one cycle before the lane ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_lane   <= {LW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_wren   <= 1'b0;
      r_addr   <= {HAW{1'b0}};
      r_be     <= {LANES{1'b0}};
      r_wrdata <= {BUS_DW{1'b0}};
      r_ack    <= 1'b0;
      r_rddata <= {BUS_DW{1'b0}};
      r_sram_a <= {SRAM_AW{1'b0}};
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_dq_out <= {SRAM_DW{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_lane   <= w_lane_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wren   <= w_wren_nxt;
      r_addr   <= w_addr_nxt;
      r_be     <= w_be_nxt;
      r_wrdata <= w_wrdata_nxt;
      r_ack    <= (w_state_nxt == ST_DONE);
      r_sram_a <= w_sram_a_nxt;
      r_ce_n   <= ~w_in_lane;
      r_oe_n   <= ~(w_in_lane & ~w_wren_nxt);
      r_we_n   <= ~(w_in_lane & w_wren_nxt & (w_cnt_nxt != LAST_CNT));
      r_dq_oe  <= w_in_lane & w_wren_nxt;
      r_dq_out <= w_dq_nxt;
      if (w_sample) begin
        r_rddata[int'(r_lane)*SRAM_DW +: SRAM_DW] <= sram_dq;
      end
    end
  end

  assign ack       = r_ack;
  assign rddata    = r_rddata;
  assign sram_a    = r_sram_a;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign sram_dq   = r_dq_oe ? r_dq_out : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a default 32/8 instance and a 16/8, single-wait instance, each on a
// behavioural async SRAM. It runs a vector table, hand-written corner sequences and random traffic.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   proto_err = 0;

  // instance 1: defaults
  logic        req1 = 1'b0, wren1 = 1'b0;
  logic [16:0] addr1 = 17'h0;
  logic [3:0]  be1 = 4'h0;
  logic [31:0] wrdata1 = 32'h0;
  logic        ack1, ce1, oe1, we1;
  logic [31:0] rddata1;
  logic [18:0] a1;
  wire  [7:0]  dq1;
  logic [7:0]  mem1 [0:524287];

  // instance 2: 16-bit bus, one wait cycle
  logic        req2 = 1'b0, wren2 = 1'b0;
  logic [17:0] addr2 = 18'h0;
  logic [1:0]  be2 = 2'h0;
  logic [15:0] wrdata2 = 16'h0;
  logic        ack2, ce2, oe2, we2;
  logic [15:0] rddata2;
  logic [18:0] a2;
  wire  [7:0]  dq2;
  logic [7:0]  mem2 [0:524287];

  sram_ctrl dut (
    .clk(clk), .reset_n(reset_n), .req(req1), .wren(wren1), .addr(addr1), .be(be1),
    .wrdata(wrdata1), .ack(ack1), .rddata(rddata1), .sram_a(a1), .sram_dq(dq1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1)
  );

  sram_ctrl #(.WAIT_CYCLES(1), .BUS_DW(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .wren(wren2), .addr(addr2), .be(be2),
    .wrdata(wrdata2), .ack(ack2), .rddata(rddata2), .sram_a(a2), .sram_dq(dq2),
    .sram_ce_n(ce2), .sram_oe_n(oe2), .sram_we_n(we2)
  );

  // Async SRAM models: read while CE and OE are low, write latched on the WE rising edge.
  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[a1] : 8'hzz;
  assign dq2 = (!ce2 && !oe2 && we2) ? mem2[a2] : 8'hzz;
  always @(posedge we1) if (!ce1) mem1[a1] <= dq1;
  always @(posedge we2) if (!ce2) mem2[a2] <= dq2;

  always @(negedge clk) begin
    if ((!oe1 && !we1) || (!oe2 && !we2)) proto_err <= proto_err + 1;
  end

  // Reference model: byte-addressed memory, unwritten bytes read as zero.
  logic [7:0] ref_mem [int];
  logic [31:0] last_rd = 32'h0;

  function automatic logic [7:0] rb(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [16:0] a);
    int base;
    base = int'(a) * 4;
    return {rb(base + 3), rb(base + 2), rb(base + 1), rb(base)};
  endfunction

  task automatic ref_write(input logic [16:0] a, input logic [3:0] b, input logic [31:0] d);
    for (int i = 0; i < 4; i++) if (b[i]) ref_mem[int'(a) * 4 + i] = d[i*8 +: 8];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction on instance 1, starting at a falling edge with the controller idle.
  task automatic txn1(input bit w, input logic [16:0] a, input logic [3:0] b, input logic [31:0] d,
                      input bit hold, output int lat, output int cec, output int oec,
                      output int wec, output logic [31:0] rd, output logic idle_ok);
    wren1 = w; addr1 = a; be1 = b; wrdata1 = d; req1 = 1'b1;
    @(posedge clk);
    #1;
    wren1 = ~w; addr1 = ~a; be1 = ~b; wrdata1 = ~d;
    lat = 0; cec = 0; oec = 0; wec = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (!ce1) cec++;
      if (!oe1) oec++;
      if (!we1) wec++;
      if (ack1) break;
    end
    if (!ack1) lat = -1;
    rd = rddata1;
    if (!hold) req1 = 1'b0;
    @(negedge clk);
    idle_ok = ce1 && oe1 && we1 && !ack1;
  endtask

  task automatic txn2(input bit w, input logic [17:0] a, input logic [1:0] b, input logic [15:0] d,
                      input bit hold, output int lat, output logic [15:0] rd, output logic idle_ok);
    wren2 = w; addr2 = a; be2 = b; wrdata2 = d; req2 = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (ack2) break;
    end
    if (!ack2) lat = -1;
    rd = rddata2;
    if (!hold) req2 = 1'b0;
    @(negedge clk);
    idle_ok = ce2 && oe2 && we2 && !ack2;
  endtask

  typedef struct {
    bit          w;
    logic [16:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_ce;
    int          exp_oe;
    int          exp_we;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cec, oec, wec;
    logic [31:0] rd;
    logic [15:0] rd2;
    logic idle_ok;

    tbl[0] = '{1'b1, 17'h00100, 4'hF, 32'hDEADBEEF, 32'h00000000, 13, 12, 0, 8};
    tbl[1] = '{1'b0, 17'h00100, 4'h0, 32'h00000000, 32'hDEADBEEF, 13, 12, 12, 0};
    tbl[2] = '{1'b1, 17'h00100, 4'h5, 32'h11223344, 32'hDEADBEEF, 7, 6, 0, 4};
    tbl[3] = '{1'b0, 17'h00100, 4'hA, 32'h00000000, 32'hDE22BE44, 13, 12, 12, 0};
    tbl[4] = '{1'b1, 17'h00100, 4'h0, 32'hFFFFFFFF, 32'hDE22BE44, 1, 0, 0, 0};
    tbl[5] = '{1'b0, 17'h00100, 4'h0, 32'h00000000, 32'hDE22BE44, 13, 12, 12, 0};
    tbl[6] = '{1'b1, 17'h1FFFF, 4'h8, 32'hA5000000, 32'hDE22BE44, 4, 3, 0, 2};
    tbl[7] = '{1'b0, 17'h1FFFF, 4'h0, 32'h00000000, 32'hA5000000, 13, 12, 12, 0};

    for (int k = 0; k < 524288; k++) begin
      mem1[k] <= 8'h00;
      mem2[k] <= 8'h00;
    end

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {63'h0, ack1}, 64'h0);
    check("rst_rddata", {32'h0, rddata1}, 64'h0);
    check("rst_sram_a", {45'h0, a1}, 64'h0);
    check("rst_strobes", {61'h0, ce1, oe1, we1}, 64'h7);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      txn1(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, 1'b0, lat, cec, oec, wec, rd, idle_ok);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_rd", i), {32'h0, rd}, {32'h0, tbl[i].exp_rd});
      check($sformatf("tbl%0d_ce", i), cec, tbl[i].exp_ce);
      check($sformatf("tbl%0d_oe", i), oec, tbl[i].exp_oe);
      check($sformatf("tbl%0d_we", i), wec, tbl[i].exp_we);
      check($sformatf("tbl%0d_idle", i), {63'h0, idle_ok}, 64'h1);
      if (tbl[i].w) ref_write(tbl[i].a, tbl[i].b, tbl[i].d);
      else last_rd = tbl[i].exp_rd;
      if (i == 0) check("mem_full_write", {32'h0, mem1[19'h403], mem1[19'h402], mem1[19'h401], mem1[19'h400]}, 64'hDEADBEEF);
      if (i == 2) check("mem_be0101", {32'h0, mem1[19'h403], mem1[19'h402], mem1[19'h401], mem1[19'h400]}, 64'hDE22BE44);
      if (i == 4) check("mem_be0000", {32'h0, mem1[19'h403], mem1[19'h402], mem1[19'h401], mem1[19'h400]}, 64'hDE22BE44);
    end

    // reset in the fifth cycle of a read
    wren1 = 1'b0; addr1 = 17'h00100; req1 = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    check("rstmid_pre_oe", {63'h0, oe1}, 64'h0);
    reset_n = 1'b0;
    #1;
    check("rstmid_strobes", {61'h0, ce1, oe1, we1}, 64'h7);
    check("rstmid_rddata", {32'h0, rddata1}, 64'h0);
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_ack", {63'h0, ack1}, 64'h0);
    reset_n = 1'b1;
    last_rd = 32'h0;
    @(negedge clk);
    txn1(1'b0, 17'h00100, 4'h0, 32'h0, 1'b0, lat, cec, oec, wec, rd, idle_ok);
    check("rstmid_read_lat", lat, 13);
    check("rstmid_read_rd", {32'h0, rd}, {32'h0, ref_word(17'h00100)});
    last_rd = rd;

    // back-to-back write then read with req held
    txn1(1'b1, 17'h00123, 4'hF, 32'h0BADF00D, 1'b1, lat, cec, oec, wec, rd, idle_ok);
    ref_write(17'h00123, 4'hF, 32'h0BADF00D);
    check("b2b_wr_lat", lat, 13);
    check("b2b_idle", {63'h0, idle_ok}, 64'h1);
    txn1(1'b0, 17'h00123, 4'h0, 32'h0, 1'b0, lat, cec, oec, wec, rd, idle_ok);
    check("b2b_rd_lat", lat, 13);
    check("b2b_rd", {32'h0, rd}, 64'h0BADF00D);
    last_rd = rd;

    // random traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      bit          w, hold;
      logic [16:0] a;
      logic [3:0]  b;
      logic [31:0] d, exp_rd;
      int          pc;
      w = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      a = 17'h00100 + 17'($urandom_range(0, 7));
      b = 4'($urandom_range(0, 15));
      d = $urandom;
      pc = $countones(b);
      exp_rd = w ? last_rd : ref_word(a);
      txn1(w, a, b, d, hold, lat, cec, oec, wec, rd, idle_ok);
      check($sformatf("rnd%0d_lat", n), lat, w ? pc * 3 + 1 : 13);
      check($sformatf("rnd%0d_rd", n), {32'h0, rd}, {32'h0, exp_rd});
      check($sformatf("rnd%0d_we", n), wec, w ? pc * 2 : 0);
      check($sformatf("rnd%0d_oe", n), oec, w ? 0 : 12);
      check($sformatf("rnd%0d_idle", n), {63'h0, idle_ok}, 64'h1);
      if (w) ref_write(a, b, d);
      else last_rd = exp_rd;
    end

    // narrow instance: back-to-back write then read
    txn2(1'b1, 18'h00055, 2'b11, 16'hCAFE, 1'b1, lat, rd2, idle_ok);
    check("n_wr_lat", lat, 5);
    check("n_wr_idle", {63'h0, idle_ok}, 64'h1);
    check("n_mem", {48'h0, mem2[19'h000AB], mem2[19'h000AA]}, 64'hCAFE);
    txn2(1'b0, 18'h00055, 2'b00, 16'h0000, 1'b0, lat, rd2, idle_ok);
    check("n_rd_lat", lat, 5);
    check("n_rd", {48'h0, rd2}, 64'hCAFE);
    txn2(1'b1, 18'h00055, 2'b10, 16'h1234, 1'b0, lat, rd2, idle_ok);
    check("n_wr_hi_lat", lat, 3);
    txn2(1'b0, 18'h00055, 2'b00, 16'h0000, 1'b0, lat, rd2, idle_ok);
    check("n_rd_hi", {48'h0, rd2}, 64'h12FE);

    check("proto_oe_we", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
